// File: rtl/branch_predict_unit_if.sv
// Fetch/EX-side signal bundle of the branch predict unit.
// Stats outputs exist only when BRANCH_STATS_EN is defined.
interface branch_predict_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] fetch_pc_i;
  logic            predict_taken_o;
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [6:0]      op_i;
  logic [2:0]      funct3_i;
  logic [3:0]      onzc_i;
  logic            ex_pred_taken_i;
  logic [1:0]      pc_source_o;
  logic            redirect_o;
`ifdef BRANCH_STATS_EN
  logic [31:0]     branch_cnt_o;
  logic [31:0]     mispredict_cnt_o;
`endif

  modport master (
    output fetch_pc_i, ex_valid_i, ex_pc_i, op_i, funct3_i, onzc_i, ex_pred_taken_i,
`ifdef BRANCH_STATS_EN
    input  branch_cnt_o, mispredict_cnt_o,
`endif
    input  predict_taken_o, pc_source_o, redirect_o
  );

  modport slave (
    input  fetch_pc_i, ex_valid_i, ex_pc_i, op_i, funct3_i, onzc_i, ex_pred_taken_i,
`ifdef BRANCH_STATS_EN
    output branch_cnt_o, mispredict_cnt_o,
`endif
    output predict_taken_o, pc_source_o, redirect_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// EX-stage branch/jump resolver with a 2-bit-counter BHT predicting at fetch.
// Optional BRANCH_STATS_EN adds branch and mispredict counters.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input logic                  clk_i,
  input logic                  rst_i,
  branch_predict_unit_if.slave bus
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'b00,
    SRC_TGT  = 2'b01,
    SRC_JALR = 2'b10,
    SRC_FALL = 2'b11
  } src_e;

  typedef struct packed {
    logic       valid;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       eq;
    logic       slt;
    logic       ult;
    logic       pred;
  } ex_req_t;

  logic [1:0]     bht_q [BHT_ENTRIES];
  src_e           src_q, src_d;
  logic           squash_q;
  ex_req_t        req;
  logic [IDX-1:0] rd_idx, wr_idx;
  logic           taken, legal, upd;
  logic [1:0]     ctr, ctr_nxt;
  logic           unused_ok;

  assign req = '{valid:  bus.ex_valid_i,
                 op:     bus.op_i,
                 funct3: bus.funct3_i,
                 eq:     bus.onzc_i[1],
                 slt:    bus.onzc_i[2],
                 ult:    bus.onzc_i[3],
                 pred:   bus.ex_pred_taken_i};

  assign rd_idx    = bus.fetch_pc_i[IDX+1:2];
  assign wr_idx    = bus.ex_pc_i[IDX+1:2];
  assign unused_ok = ^{bus.onzc_i[0], bus.fetch_pc_i[XLEN-1:IDX+2], bus.fetch_pc_i[1:0],
                       bus.ex_pc_i[XLEN-1:IDX+2], bus.ex_pc_i[1:0]};

  assign bus.predict_taken_o = bht_q[rd_idx][1];
  assign bus.pc_source_o     = src_q;
  assign bus.redirect_o      = (src_q != SRC_SEQ);

  always_comb begin
    unique case (req.funct3)
      3'b000:  taken = req.eq;
      3'b001:  taken = !req.eq;
      3'b100:  taken = req.slt;
      3'b101:  taken = !req.slt;
      3'b110:  taken = req.ult;
      3'b111:  taken = !req.ult;
      default: taken = 1'b0;
    endcase
  end

  assign legal = (req.funct3[2:1] != 2'b01);

  // Squash drops the wrong-path instruction sitting in EX behind a redirect.
  always_comb begin
    src_d = SRC_SEQ;
    upd   = 1'b0;
    if (req.valid && !squash_q && req.op[6]) begin
      if (req.op[3:2] == 2'b01)      src_d = SRC_JALR;
      else if (req.op[3:2] == 2'b11) src_d = SRC_TGT;
      else if (legal) begin
        upd = 1'b1;
        if (taken != req.pred) src_d = taken ? SRC_TGT : SRC_FALL;
      end
    end
  end

  assign ctr     = bht_q[wr_idx];
  assign ctr_nxt = taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                         : ((ctr == 2'b00) ? ctr : ctr - 2'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      src_q    <= SRC_SEQ;
      squash_q <= 1'b0;
    end else begin
      src_q    <= src_d;
      squash_q <= (src_d != SRC_SEQ);
      if (upd) bht_q[wr_idx] <= ctr_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (upd) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (src_d != SRC_SEQ) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign bus.branch_cnt_o     = branch_cnt_q;
  assign bus.mispredict_cnt_o = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized bench for branch_predict_unit against a queue-free
// behavioural model of the BHT and redirect rules (4-entry BHT to force aliasing).
module tb_branch_predict_unit;
  localparam int ENT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int       m_ctr [ENT];
  int       m_src;
  bit       m_sq;
  int       m_bcnt, m_mcnt;

  branch_predict_unit_if #(.XLEN(32)) bus ();

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(ENT), .CTR_INIT(2'b01)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_ctr[i] = 1;
    m_src = 0; m_sq = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  // Expected behaviour expressed directly from the branch rules.
  task automatic model_step(input logic v, input logic [31:0] pc, input logic [6:0] op,
                            input logic [2:0] f3, input logic [3:0] fl, input logic pr);
    int  src;
    bit  t, legal;
    int  k;
    src = 0;
    if (v && !m_sq && op[6]) begin
      if (op[3:2] == 2'b01)      src = 2;
      else if (op[3:2] == 2'b11) src = 1;
      else begin
        legal = 1;
        case (f3)
          0: t = fl[1];   1: t = !fl[1];
          4: t = fl[2];   5: t = !fl[2];
          6: t = fl[3];   7: t = !fl[3];
          default: legal = 0;
        endcase
        if (legal) begin
          k = idx(pc);
          m_ctr[k] = t ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3) : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
          m_bcnt++;
          if (t != pr) begin
            src = t ? 1 : 3;
            m_mcnt++;
          end
        end
      end
    end
    m_src = src;
    m_sq  = (src != 0);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [6:0] op,
                      input logic [2:0] f3, input logic [3:0] fl, input logic pr,
                      input logic [31:0] fpc);
    bus.ex_valid_i = v; bus.ex_pc_i = pc; bus.op_i = op; bus.funct3_i = f3;
    bus.onzc_i = fl; bus.ex_pred_taken_i = pr; bus.fetch_pc_i = fpc;
    #1;
    chk("predict_taken", {31'd0, bus.predict_taken_o}, {31'd0, m_ctr[idx(fpc)] >= 2});
    model_step(v, pc, op, f3, fl, pr);
    @(posedge clk); #1;
    chk("pc_source", {30'd0, bus.pc_source_o}, m_src);
    chk("redirect", {31'd0, bus.redirect_o}, {31'd0, m_src != 0});
`ifdef BRANCH_STATS_EN
    chk("branch_cnt", bus.branch_cnt_o, m_bcnt);
    chk("mispredict_cnt", bus.mispredict_cnt_o, m_mcnt);
`endif
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(1'b0, 32'h0, 7'h0, 3'h0, 4'h0, 1'b0, fpc);
  endtask

  initial begin
    logic [6:0]  op;
    logic [31:0] pc;
    bit          pr;
    model_reset();
    bus.ex_valid_i = 0; bus.ex_pc_i = 0; bus.op_i = 0; bus.funct3_i = 0;
    bus.onzc_i = 0; bus.ex_pred_taken_i = 0; bus.fetch_pc_i = 32'h100;
    #12;
    chk("rst_pc_source", {30'd0, bus.pc_source_o}, 0);
    chk("rst_redirect", {31'd0, bus.redirect_o}, 0);
    chk("rst_predict", {31'd0, bus.predict_taken_o}, 0);
    rst = 0;

    // beq taken, predicted not taken -> target redirect, counter 01->10
    idle(32'h100);
    step(1, 32'h100, 7'h63, 3'b000, 4'b0010, 0, 32'h100);
    chk("beq_src", {30'd0, bus.pc_source_o}, 1);
    idle(32'h100);
    chk("beq_ctr_now_taken", {31'd0, bus.predict_taken_o}, 1);

    // bne mispredict, then a jal in the squash shadow is dropped
    step(1, 32'h104, 7'h63, 3'b001, 4'b0000, 0, 32'h104);
    step(1, 32'h108, 7'h6F, 3'b000, 4'b0000, 0, 32'h108);
    chk("squash_jal", {30'd0, bus.pc_source_o}, 0);

    // bltu not taken while predicted taken -> fall-through, then saturate at 00
    step(1, 32'h200, 7'h63, 3'b110, 4'b0000, 1, 32'h200);
    chk("bltu_fall", {30'd0, bus.pc_source_o}, 3);
    for (int i = 0; i < 3; i++) step(1, 32'h200, 7'h63, 3'b110, 4'b0000, 0, 32'h200);
    chk("bltu_sat", {31'd0, bus.predict_taken_o}, 0);

    step(1, 32'h300, 7'h6F, 3'b000, 4'h0, 0, 32'h300);
    chk("jal", {30'd0, bus.pc_source_o}, 1);
    idle(32'h300);
    step(1, 32'h304, 7'h67, 3'b000, 4'h0, 0, 32'h304);
    chk("jalr", {30'd0, bus.pc_source_o}, 2);
    idle(32'h304);
    step(1, 32'h308, 7'h33, 3'b000, 4'h0, 0, 32'h308);
    step(1, 32'h30C, 7'h63, 3'b010, 4'b0010, 1, 32'h30C);
    chk("illegal_f3", {30'd0, bus.pc_source_o}, 0);

    // 0x0 and 0x10 alias onto entry 0
    step(1, 32'h0, 7'h63, 3'b000, 4'b0010, 0, 32'h10);
    idle(32'h10);
    step(1, 32'h10, 7'h63, 3'b000, 4'b0010, 0, 32'h0);
    idle(32'h0);

    // reset pulse between EX and the registered output
    bus.ex_valid_i = 1; bus.ex_pc_i = 32'h40; bus.op_i = 7'h63; bus.funct3_i = 3'b000;
    bus.onzc_i = 4'b0010; bus.ex_pred_taken_i = 0;
    @(posedge clk); #1;
    chk("pre_rst_redirect", {31'd0, bus.redirect_o}, 1);
    rst = 1; bus.ex_valid_i = 0;
    #1;
    model_reset();
    chk("mid_rst_src", {30'd0, bus.pc_source_o}, 0);
    chk("mid_rst_redirect", {31'd0, bus.redirect_o}, 0);
    rst = 0;
    idle(32'h40);

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 3; i++) step(1, 32'h20, 7'h63, 3'b000, 4'b0000, 0, 32'h20);
    step(1, 32'h24, 7'h63, 3'b000, 4'b0010, 0, 32'h24);
    idle(32'h24);
    step(1, 32'h28, 7'h63, 3'b000, 4'b0010, 0, 32'h28);
    idle(32'h28);
    chk("stats_branches", bus.branch_cnt_o, 5);
    chk("stats_mispred", bus.mispredict_cnt_o, 2);
`endif

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: op = 7'h63;
        3:       op = 7'h6F;
        4:       op = 7'h67;
        default: op = 7'($urandom);
      endcase
      pc = $urandom & 32'hFF;
      pr = ($urandom_range(0, 1) == 1) ? bit'($urandom) : (m_ctr[idx(pc)] >= 2);
      step($urandom_range(0, 9) != 0, pc, op, 3'($urandom), 4'($urandom), pr,
           $urandom & 32'hFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
